decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Fetch->execute decode pipeline stage of the RISC-V core (RV64IM). Accepts one instruction per
//  cycle from fetch, forms the 12-bit control-store address {inst[6:0],inst[14:12],inst[30],inst[25]},
//  captures the returned 19-bit control word together with rs1/rs2/rd, a sign-extended immediate and
//  the PC in a registered output stage, and interlocks load-use hazards against the held instruction.
// PARAMETERS
//  XLEN      64   datapath width for PC and immediate
//  CNT_W     32   width of load-use bubble counter
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous, active-high reset
//  fe_valid      in   1       fetch presents an instruction
//  fe_ready      out  1       decode accepts instruction this cycle
//  fe_inst       in   32      instruction word
//  fe_pc         in   XLEN    instruction PC
//  cs_addr       out  12      control-store address (combinational from fe_inst)
//  cs_ctrl       in   19      control word returned combinationally by control store
//  flush         in   1       redirect: kill held and incoming instruction
//  de_ready      in   1       execute accepts de_* this cycle
//  de_valid      out  1       de_* outputs hold a valid instruction
//  de_pc         out  XLEN    registered PC
//  de_ctrl       out  19      registered control word (bit0 reg write, bit1 load, bit5 store)
//  de_rs1/de_rs2 out  5 each  inst[19:15], inst[24:20]
//  de_rd         out  5       inst[11:7]
//  de_imm        out  XLEN    immediate, sign-extended to XLEN
//  de_illegal    out  1       held instruction is illegal
//  bubble_cnt    out  CNT_W   load-use bubbles inserted since reset (saturating)
// BEHAVIOUR
//  - One clock domain; one clock and one asynchronous, active-high reset (rst). On reset all de_* and
//    bubble_cnt = 0.
//  - adv = !de_valid | de_ready. hz = de_valid & de_ctrl[1] & de_rd!=0 & (de_rd==rs1 | de_rd==rs2),
//    rs1/rs2 taken from fe_inst fields regardless of format (conservative).
//  - fe_ready = adv & !hz & !flush. Accept = fe_valid & fe_ready; accepted instr appears on de_* next
//    cycle (latency 1).
//  - Output register, priority order: flush -> de_valid<=0; else adv & hz -> bubble (de_valid<=0,
//    bubble_cnt+=1, saturates at all-ones); else adv -> de_valid<=accept, fields load; else hold all.
//  - While held (!adv) every de_* is stable. Bubble/flush clear de_valid only; data fields don't-care.
//  - Immediate by opcode: I (LOAD, OP-IMM, OP-IMM-32, JALR), S (STORE), B (BRANCH), U (LUI, AUIPC),
//    J (JAL); OP/OP-32 -> 0. U-type = {inst[31:12],12'b0} sign-extended from bit 31.
//  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011,
//    0011011, 0111011. Also illegal: BRANCH funct3 010/011, LOAD funct3 111, STORE funct3 1xx.
//    Illegal -> de_illegal=1, de_ctrl=0 (no reg write/load/store), de_valid=1 so trap is taken in order.
//  - cs_ctrl sampled only on a legal accept; unmapped control-store contents never reach de_ctrl.
//  - Reset mid-stall or mid-hold: outputs clear immediately; no pending state survives.
// TESTING
//  - ADD x3,x1,x2 (0x002081B3), de_ready=1 -> cs_addr=0x660; next cycle de_valid=1, rs1=1, rs2=2,
//    rd=3, de_imm=0, de_ctrl=cs_ctrl.
//  - LW x5,8(x1) (0x0080A283) then ADD x6,x5,x1 (0x00128333) -> cs_addr=0x068, de_imm=8; ADD held one
//    cycle (fe_ready=0), one bubble (de_valid=0), bubble_cnt=1, ADD issues next cycle.
//  - ADDI x1,x0,-1 (0xFFF00093) -> de_imm=0xFFFFFFFFFFFFFFFF; LUI x2,0x80000 (0x80000137) ->
//    de_imm=0xFFFFFFFF80000000.
//  - de_ready=0 for 3 cycles with fe_valid=1 -> fe_ready=0, de_* unchanged; de_ready=1 -> next instr.
//  - flush asserted with de_valid=1 and fe_valid=1 -> fe_ready=0, de_valid=0 next cycle, nothing issued.
//  - inst 0x0000007F -> de_illegal=1, de_ctrl=0, de_valid=1; rst pulse mid-hold -> all outputs 0.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage between fetch and execute: forms the control-store address, registers the decoded
// fields and control word, and inserts a bubble when the held load feeds the incoming instruction.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fe_valid,
  output logic             fe_ready,
  input  logic [31:0]      fe_inst,
  input  logic [XLEN-1:0]  fe_pc,
  output logic [11:0]      cs_addr,
  input  logic [18:0]      cs_ctrl,
  input  logic             flush,
  input  logic             de_ready,
  output logic             de_valid,
  output logic [XLEN-1:0]  de_pc,
  output logic [18:0]      de_ctrl,
  output logic [4:0]       de_rs1,
  output logic [4:0]       de_rs2,
  output logic [4:0]       de_rd,
  output logic [XLEN-1:0]  de_imm,
  output logic             de_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            adv;
  logic            hz;
  logic            accept;
  logic            legal;
  logic [XLEN-1:0] imm;

  assign opcode  = fe_inst[6:0];
  assign funct3  = fe_inst[14:12];
  assign rs1     = fe_inst[19:15];
  assign rs2     = fe_inst[24:20];
  assign rd      = fe_inst[11:7];
  assign cs_addr = {fe_inst[6:0], fe_inst[14:12], fe_inst[30], fe_inst[25]};

  // rs1/rs2 compared for every format, even where the field is not a source register
  assign adv      = !de_valid || de_ready;
  assign hz       = de_valid && de_ctrl[1] && (de_rd != 5'd0) && ((de_rd == rs1) || (de_rd == rs2));
  assign fe_ready = adv && !hz && !flush;
  assign accept   = fe_valid && fe_ready;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_IMM, OP_OP, OP_IMM32, OP_OP32: legal = 1'b1;
      OP_BRANCH:                        legal = (funct3[2:1] != 2'b01);
      OP_LOAD:                          legal = (funct3 != 3'b111);
      OP_STORE:                         legal = !funct3[2];
      default:                          legal = 1'b0;
    endcase
  end

  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:
        imm = {{(XLEN-12){fe_inst[31]}}, fe_inst[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){fe_inst[31]}}, fe_inst[31:25], fe_inst[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){fe_inst[31]}}, fe_inst[31], fe_inst[7], fe_inst[30:25], fe_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {{(XLEN-32){fe_inst[31]}}, fe_inst[31:12], 12'b0};
      OP_JAL:
        imm = {{(XLEN-21){fe_inst[31]}}, fe_inst[31], fe_inst[19:12], fe_inst[20], fe_inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  // Illegal instructions still issue so the trap is taken in order, but carry no control bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_valid   <= 1'b0;
      de_pc      <= '0;
      de_ctrl    <= '0;
      de_rs1     <= '0;
      de_rs2     <= '0;
      de_rd      <= '0;
      de_imm     <= '0;
      de_illegal <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush) begin
      de_valid <= 1'b0;
    end else if (adv && hz) begin
      de_valid <= 1'b0;
      if (bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (adv) begin
      de_valid <= accept;
      if (accept) begin
        de_pc      <= fe_pc;
        de_ctrl    <= legal ? cs_ctrl : 19'd0;
        de_rs1     <= rs1;
        de_rs2     <= rs2;
        de_rd      <= rd;
        de_imm     <= imm;
        de_illegal <= !legal;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage, checked against a behavioural model of the stage.
module tb_decode_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             fe_valid;
  logic             fe_ready;
  logic [31:0]      fe_inst;
  logic [XLEN-1:0]  fe_pc;
  logic [11:0]      cs_addr;
  logic [18:0]      cs_ctrl;
  logic             flush;
  logic             de_ready;
  logic             de_valid;
  logic [XLEN-1:0]  de_pc;
  logic [18:0]      de_ctrl;
  logic [4:0]       de_rs1;
  logic [4:0]       de_rs2;
  logic [4:0]       de_rd;
  logic [XLEN-1:0]  de_imm;
  logic             de_illegal;
  logic [CNT_W-1:0] bubble_cnt;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_inst(fe_inst),
    .fe_pc(fe_pc), .cs_addr(cs_addr), .cs_ctrl(cs_ctrl), .flush(flush), .de_ready(de_ready),
    .de_valid(de_valid), .de_pc(de_pc), .de_ctrl(de_ctrl), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rd(de_rd), .de_imm(de_imm), .de_illegal(de_illegal), .bubble_cnt(bubble_cnt)
  );

  // Control store contents: random words, with the load bit set only for LOAD-opcode entries
  logic [18:0] cs_mem [0:4095];
  assign cs_ctrl = cs_mem[cs_addr];

  int checks = 0;
  int errors = 0;

  logic        m_valid;
  logic [63:0] m_pc;
  logic [63:0] m_imm;
  logic [18:0] m_ctrl;
  logic [4:0]  m_rs1;
  logic [4:0]  m_rs2;
  logic [4:0]  m_rd;
  logic        m_ill;
  int          m_bub;

  function automatic logic [11:0] exp_addr(input logic [31:0] inst);
    return {inst[6:0], inst[14:12], inst[30], inst[25]};
  endfunction

  function automatic logic is_legal(input logic [31:0] inst);
    logic [6:0] op;
    int f3;
    op = inst[6:0];
    f3 = int'(inst[14:12]);
    if (op == 7'b1100011) return !(f3 == 2 || f3 == 3);
    if (op == 7'b0000011) return f3 != 7;
    if (op == 7'b0100011) return f3 < 4;
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011,
                      7'b0110011, 7'b0011011, 7'b0111011};
  endfunction

  function automatic logic [63:0] exp_imm(input logic [31:0] inst);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    longint v;
    v = 0;
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin i12 = inst[31:20]; v = i12; end
      7'b0100011: begin i12 = {inst[31:25], inst[11:7]}; v = i12; end
      7'b1100011: begin b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; v = b13; end
      7'b0110111, 7'b0010111: begin u32 = {inst[31:12], 12'b0}; v = u32; end
      7'b1101111: begin j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; v = j21; end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_valid = 1'b0; m_pc = '0; m_imm = '0; m_ctrl = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ill = 1'b0; m_bub = 0;
  endtask

  task automatic checkRegs();
    checkOutput("de_valid", 64'(de_valid), 64'(m_valid));
    checkOutput("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    if (m_valid) begin
      checkOutput("de_pc", de_pc, m_pc);
      checkOutput("de_ctrl", 64'(de_ctrl), 64'(m_ctrl));
      checkOutput("de_rs1", 64'(de_rs1), 64'(m_rs1));
      checkOutput("de_rs2", 64'(de_rs2), 64'(m_rs2));
      checkOutput("de_rd", 64'(de_rd), 64'(m_rd));
      checkOutput("de_illegal", 64'(de_illegal), 64'(m_ill));
      if (!m_ill) checkOutput("de_imm", de_imm, m_imm);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational outputs, then the registered result
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                               input logic rdy, input logic fl);
    logic adv, hz, frdy, acc;
    fe_valid = v; fe_inst = inst; fe_pc = pc; de_ready = rdy; flush = fl;
    #1;
    adv  = !m_valid || rdy;
    hz   = m_valid && m_ctrl[1] && m_rd != 0 && (m_rd == inst[19:15] || m_rd == inst[24:20]);
    frdy = adv && !hz && !fl;
    acc  = v && frdy;
    checkOutput("cs_addr", 64'(cs_addr), 64'(exp_addr(inst)));
    checkOutput("fe_ready", 64'(fe_ready), 64'(frdy));
    @(posedge clk);
    #1;
    if (fl) m_valid = 1'b0;
    else if (adv && hz) begin
      m_valid = 1'b0;
      if (m_bub < CNT_MAX) m_bub++;
    end else if (adv) begin
      m_valid = acc;
      if (acc) begin
        m_ill  = !is_legal(inst);
        m_ctrl = m_ill ? 19'd0 : cs_mem[exp_addr(inst)];
        m_pc   = pc;
        m_rs1  = inst[19:15];
        m_rs2  = inst[24:20];
        m_rd   = inst[11:7];
        m_imm  = exp_imm(inst);
      end
    end
    checkRegs();
  endtask

  logic [6:0] ops [14] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011,
                           7'b0111011, 7'b1111111, 7'b0000000, 7'b0001111};

  initial begin
    logic [18:0] w;
    logic [11:0] a;
    logic [31:0] ri;
    for (int i = 0; i < 4096; i++) begin
      a = 12'(i);
      w = 19'($urandom);
      w[1] = (a[11:5] == 7'b0000011);
      cs_mem[i] = w;
    end
    $display("[TB] decode_stage bench start");
    rst = 1'b1; fe_valid = 1'b0; fe_inst = '0; fe_pc = '0; de_ready = 1'b0; flush = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pc", de_pc, 64'd0);
    checkOutput("rst_ctrl", 64'(de_ctrl), 64'd0);
    checkOutput("rst_imm", de_imm, 64'd0);
    checkRegs();
    rst = 1'b0;

    applyStimulus(1'b1, 32'h002081B3, 64'h1000, 1'b1, 1'b0);
    checkOutput("add_cs_addr", 64'(cs_addr), 64'h660);
    checkOutput("add_rd", 64'(de_rd), 64'd3);
    checkOutput("add_imm", de_imm, 64'd0);

    applyStimulus(1'b1, 32'h0080A283, 64'h1004, 1'b1, 1'b0);
    checkOutput("lw_cs_addr", 64'(cs_addr), 64'h068);
    checkOutput("lw_imm", de_imm, 64'd8);
    applyStimulus(1'b1, 32'h00128333, 64'h1008, 1'b1, 1'b0);
    checkOutput("lu_bubble_valid", 64'(de_valid), 64'd0);
    checkOutput("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
    applyStimulus(1'b1, 32'h00128333, 64'h1008, 1'b1, 1'b0);
    checkOutput("lu_issue_rd", 64'(de_rd), 64'd6);

    applyStimulus(1'b1, 32'hFFF00093, 64'h100C, 1'b1, 1'b0);
    checkOutput("addi_imm", de_imm, 64'hFFFFFFFFFFFFFFFF);
    applyStimulus(1'b1, 32'h80000137, 64'h1010, 1'b1, 1'b0);
    checkOutput("lui_imm", de_imm, 64'hFFFFFFFF80000000);

    repeat (3) applyStimulus(1'b1, 32'h00500193, 64'h1014, 1'b0, 1'b0);
    checkOutput("hold_pc", de_pc, 64'h1010);
    applyStimulus(1'b1, 32'h00500193, 64'h1014, 1'b1, 1'b0);
    checkOutput("release_pc", de_pc, 64'h1014);

    applyStimulus(1'b1, 32'h002081B3, 64'h1018, 1'b1, 1'b1);
    checkOutput("flush_valid", 64'(de_valid), 64'd0);

    applyStimulus(1'b1, 32'h0000007F, 64'h101C, 1'b1, 1'b0);
    checkOutput("ill_flag", 64'(de_illegal), 64'd1);
    checkOutput("ill_ctrl", 64'(de_ctrl), 64'd0);
    checkOutput("ill_valid", 64'(de_valid), 64'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h0080A283, 64'h2000, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00128333, 64'h2004, 1'b1, 1'b0);
    end
    checkOutput("bubble_saturate", 64'(bubble_cnt), 64'(CNT_MAX));

    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      ri[6:0]   = ops[$urandom_range(0, 13)];
      ri[11:7]  = 5'($urandom_range(0, 3));
      ri[19:15] = 5'($urandom_range(0, 3));
      ri[24:20] = 5'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 4) != 0), ri, {32'h0, $urandom},
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    applyStimulus(1'b1, 32'h002081B3, 64'h3000, 1'b1, 1'b0);
    de_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 64'(de_valid), 64'd0);
    checkOutput("midrst_pc", de_pc, 64'd0);
    checkOutput("midrst_ctrl", 64'(de_ctrl), 64'd0);
    checkOutput("midrst_regs", 64'({de_rs1, de_rs2, de_rd}), 64'd0);
    checkOutput("midrst_imm", de_imm, 64'd0);
    checkOutput("midrst_ill", 64'(de_illegal), 64'd0);
    checkOutput("midrst_bub", 64'(bubble_cnt), 64'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkRegs();
    applyStimulus(1'b1, 32'h00500193, 64'h3004, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
